axi_line_fill: RTL

//  AXI4 read master that refills one cache line on a miss. Sits between the cache controller and the AXI fabric.

---
 rtl/axi_line_fill.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axi_line_fill.sv
// AXI4 read master that refills one cache line per miss with a single INCR burst.
// Defining FILL_ERR_EN adds fill_err, which flags a bad response or misplaced rlast in the burst.
module axi_line_fill #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fill_req,
    input  logic [ADDR_W-1:0] fill_addr,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_data_valid,
    output logic              mem_last,
    output logic [3:0]        mem_wstb,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast
`ifdef FILL_ERR_EN
    ,
    output logic              fill_err
`endif
);
    localparam int WORD_BYTES = DATA_W / 8;
    localparam int BEATS      = LINE_BYTES / WORD_BYTES;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_OFF_W = $clog2(LINE_BYTES);
    localparam int WORD_OFF_W = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] line_base;
    logic              start;
    logic              beat_ok;

    assign line_base = {fill_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    assign start     = (state == IDLE) && fill_req;
    assign beat_ok   = rvalid && rready;

    assign mem_addr = (state == IDLE) ? fill_addr : word_addr;
    assign araddr   = base;
    assign arlen    = 8'(BEATS - 1);
    assign arsize   = 3'(WORD_OFF_W);
    assign arburst  = 2'b01;
    assign mem_wstb = 4'b1111;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        case (state)
            IDLE: if (fill_req) state_next = ADDR;
            ADDR: begin
                busy    = 1'b1;
                arvalid = 1'b1;
                if (arready) state_next = DATA;
            end
            DATA: begin
                busy   = 1'b1;
                // Back-pressure for one cycle after each accepted beat so the cache sees isolated pulses.
                rready = !mem_data_valid;
                if (mem_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt            <= '0;
            base           <= '0;
            word_addr      <= '0;
            mem_data_in    <= '0;
            mem_data_valid <= 1'b0;
            mem_last       <= 1'b0;
        end else begin
            mem_data_valid <= 1'b0;
            mem_last       <= 1'b0;
            if (start) begin
                base      <= line_base;
                word_addr <= line_base;
                cnt       <= '0;
            end
            if (beat_ok) begin
                mem_data_valid <= 1'b1;
                mem_last       <= (cnt == LAST_CNT);
                mem_data_in    <= rdata;
                word_addr      <= base + ADDR_W'({cnt, {WORD_OFF_W{1'b0}}});
                cnt            <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef FILL_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset_n)  err_q <= 1'b0;
        else if (start) err_q <= 1'b0;
        else if (beat_ok && ((rresp != 2'b00) || (rlast != (cnt == LAST_CNT))))
            err_q <= 1'b1;
    end

    // The last beat's own error is already folded into err_q by the mem_last cycle.
    assign fill_err = mem_last && err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, rlast};
`endif

endmodule
